// File: rtl/button_pulse_bank.sv
// Multi-channel button synchroniser, debouncer and press-pulse generator.
// Define AUTO_REPEAT_EN to add hold-to-repeat pulses per channel.
module button_pulse_bank #(
   parameter int N_CH            = 2,
   parameter int DEBOUNCE_CYCLES = 2000000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic            basys_clk,
   input  logic            clr,
   input  logic [N_CH-1:0] btn_raw,
   output logic [N_CH-1:0] btn_level,
   output logic [N_CH-1:0] btn_pulse,
   output logic            any_pulse,
   output logic [N_CH-1:0] busy
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } state_e;

   logic [N_CH-1:0] sync1_q;
   logic [N_CH-1:0] sync2_q;

   always_ff @(posedge basys_clk or negedge clr) begin
      if (!clr) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      state_e        state_q;
      state_e        state_d;
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          pulse_q;
      logic          pulse_d;
      logic          rep_fire;
      logic          s;

      assign s = sync2_q[i];

      always_ff @(posedge basys_clk or negedge clr) begin
         if (!clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
         end
      end

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         unique case (state_q)
            IDLE: begin
               if (s) begin
                  state_d = PRESS_WAIT;
                  cnt_d   = CNT_ONE;
               end
            end
            PRESS_WAIT: begin
               if (!s) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (cnt_q >= CNT_LAST) begin
                  state_d = HELD;
                  cnt_d   = '0;
               end else if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            HELD: begin
               if (!s) begin
                  state_d = RELEASE_WAIT;
                  cnt_d   = CNT_ONE;
               end
            end
            RELEASE_WAIT: begin
               if (s) begin
                  state_d = HELD;
                  cnt_d   = '0;
               end else if (cnt_q >= CNT_LAST) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end

`ifdef AUTO_REPEAT_EN
      localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                            REPEAT_DELAY : REPEAT_PERIOD;
      localparam int HW = $clog2(RMAX + 1);
      localparam logic [HW-1:0] H_ONE   = HW'(1);
      localparam logic [HW-1:0] H_MAX   = HW'(RMAX);
      localparam logic [HW-1:0] H_DELAY = HW'(REPEAT_DELAY - 1);
      localparam logic [HW-1:0] H_PER   = HW'(REPEAT_PERIOD - 1);

      logic [HW-1:0] hold_q;
      logic          first_q;

      assign rep_fire = (state_q == HELD) && s &&
                        (hold_q == (first_q ? H_DELAY : H_PER));

      // Hold time freezes during a release bounce and clears only on a real release.
      always_ff @(posedge basys_clk or negedge clr) begin
         if (!clr) begin
            hold_q  <= '0;
            first_q <= 1'b1;
         end else if (state_q == IDLE || state_q == PRESS_WAIT) begin
            hold_q  <= '0;
            first_q <= 1'b1;
         end else if (state_q == HELD && s) begin
            if (rep_fire) begin
               hold_q  <= '0;
               first_q <= 1'b0;
            end else if (hold_q != H_MAX) begin
               hold_q <= hold_q + H_ONE;
            end
         end
      end
`else
      assign rep_fire = 1'b0;
`endif

      always_comb begin
         pulse_d = rep_fire ||
                   (state_q == PRESS_WAIT && state_d == HELD);
         btn_level[i] = (state_q == HELD) ||
                        (state_q == RELEASE_WAIT);
         busy[i] = (state_q == PRESS_WAIT) ||
                   (state_q == RELEASE_WAIT);
      end

      assign btn_pulse[i] = pulse_q;
   end

   assign any_pulse = |btn_pulse;

endmodule

// File: tb/tb_button_pulse_bank.sv
// Directed bench for button_pulse_bank with a pulse scoreboard.
// Build with AUTO_REPEAT_EN to check the repeat pulse train.
module tb_button_pulse_bank;

   localparam int D  = 8;
   localparam int RD = 20;
   localparam int RP = 5;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic [1:0] btn_raw = 2'b11;
   logic [1:0] btn_level;
   logic [1:0] btn_pulse;
   logic       any_pulse;
   logic [1:0] busy;

   typedef struct {
      int         c;
      logic [1:0] m;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   p;

   button_pulse_bank #(
      .N_CH(2),
      .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY(RD),
      .REPEAT_PERIOD(RP)
   ) dut (
      .basys_clk(clk),
      .clr(clr),
      .btn_raw(btn_raw),
      .btn_level(btn_level),
      .btn_pulse(btn_pulse),
      .any_pulse(any_pulse),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s @cyc %0d: observed %0h expected %0h",
                tag, cyc, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int c, input logic [1:0] m);
      exp_t e;
      e.c = c;
      e.m = m;
      q.push_back(e);
   endtask

   // Every pulse the DUT raises, and every expected pulse, gets compared.
   always @(negedge clk) begin
      exp_t e;
      if (btn_pulse !== 2'b00 || (q.size() > 0 && q[0].c == cyc)) begin
         if (q.size() > 0 && q[0].c == cyc) begin
            e = q.pop_front();
         end else begin
            e.c = cyc;
            e.m = 2'b00;
         end
         chk("pulse", 32'(btn_pulse), 32'(e.m));
         chk("any_pulse", 32'(any_pulse), 32'(|e.m));
      end
   end

   initial begin
      // reset with both buttons held
      tick(10);
      chk("rst_level", 32'(btn_level), 0);
      chk("rst_pulse", 32'(btn_pulse), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_any", 32'(any_pulse), 0);
      clr = 1'b1;
      p = cyc;
      push(p + D + 2, 2'b11);
      tick(12);
      chk("post_rst_level", 32'(btn_level), 32'h3);
      btn_raw = 2'b00;
      tick(9);
      chk("rel_level_hold", 32'(btn_level), 32'h3);
      chk("rel_busy", 32'(busy), 32'h3);
      tick(1);
      chk("rel_level_fall", 32'(btn_level), 0);
      tick(5);

      // clean press on channel 0
      btn_raw = 2'b01;
      p = cyc;
      push(p + D + 2, 2'b01);
      tick(9);
      chk("c0_busy", 32'(busy), 32'h1);
      chk("c0_level_pre", 32'(btn_level), 0);
      tick(1);
      chk("c0_level", 32'(btn_level), 32'h1);
      tick(5);
      chk("c0_busy_done", 32'(busy), 0);
      btn_raw = 2'b00;
      tick(14);
      chk("c0_released", 32'(btn_level), 0);

      // bouncing press on channel 1
      btn_raw = 2'b10;
      tick(3);
      chk("b1_busy", 32'(busy), 32'h2);
      btn_raw = 2'b00;
      tick(3);
      btn_raw = 2'b10;
      tick(3);
      btn_raw = 2'b00;
      tick(3);
      chk("b1_level_bounce", 32'(btn_level), 0);
      btn_raw = 2'b10;
      p = cyc;
      push(p + D + 2, 2'b10);
      tick(9);
      chk("b1_busy_filter", 32'(busy), 32'h2);
      tick(1);
      chk("b1_level", 32'(btn_level), 32'h2);
      tick(5);

      // short release glitch while held
      btn_raw = 2'b00;
      tick(5);
      chk("g_busy", 32'(busy), 32'h2);
      chk("g_level", 32'(btn_level), 32'h2);
      btn_raw = 2'b10;
      tick(5);
      chk("g_busy_done", 32'(busy), 0);
      chk("g_level_kept", 32'(btn_level), 32'h2);
      btn_raw = 2'b00;
      tick(9);
      chk("g_level_hold", 32'(btn_level), 32'h2);
      tick(1);
      chk("g_level_fall", 32'(btn_level), 0);
      tick(10);

      // simultaneous press, reset mid-debounce, re-debounce
      btn_raw = 2'b11;
      tick(6);
      chk("sim_busy", 32'(busy), 32'h3);
      clr = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_level", 32'(btn_level), 0);
      chk("mid_rst_pulse", 32'(btn_pulse), 0);
      tick(2);
      clr = 1'b1;
      p = cyc;
      push(p + D + 2, 2'b11);
      tick(12);
      chk("sim_level", 32'(btn_level), 32'h3);
      btn_raw = 2'b00;
      tick(14);
      chk("sim_released", 32'(btn_level), 0);

      // long hold on channel 0
      btn_raw = 2'b01;
      p = cyc;
      push(p + D + 2, 2'b01);
`ifdef AUTO_REPEAT_EN
      for (int k = 0; k < 5; k++) push(p + D + 2 + RD + k * RP, 2'b01);
`endif
      tick(D + 2 + 42);
      chk("hold_level", 32'(btn_level), 32'h1);
      btn_raw = 2'b00;
      tick(14);
      chk("hold_released", 32'(btn_level), 0);

      chk("queue_drained", 32'(q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
